keypad_scan_ctrl: RTL



---
 rtl/keypad_scan_ctrl.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/keypad_scan_ctrl.sv
// 4x4 hex keypad controller: timed row scan, press/release debounce, one event per
// accepted press, and a two-digit history of accepted keys.
module keypad_scan_ctrl #(
   parameter int unsigned SCAN_DIV     = 24000,
   parameter int unsigned DEBOUNCE_CYC = 480000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] cols_n,
   output logic [3:0] rows_n,
   output logic       key_valid,
   output logic [3:0] key_code,
   output logic       key_held,
   output logic [3:0] digit_new,
   output logic [3:0] digit_old
);

   localparam int unsigned DW = $clog2(SCAN_DIV);
   localparam int unsigned BW = $clog2(DEBOUNCE_CYC);
   localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
   localparam logic [BW-1:0] DB_LAST    = BW'(DEBOUNCE_CYC - 1);

   typedef enum logic [1:0] {StScan, StDebounce, StHeld, StRelease} state_t;

   state_t        r_state, w_state_nxt;
   logic [3:0]    r_cols_meta, r_cols_s;
   logic [1:0]    r_row, w_row_nxt;
   logic [1:0]    r_col, w_col_nxt;
   logic [DW-1:0] r_dwell, w_dwell_nxt;
   logic [BW-1:0] r_db, w_db_nxt;
   logic          r_key_valid;
   logic [3:0]    r_key_code, r_digit_new, r_digit_old;
   logic          w_fire;
   logic          w_any_low;
   logic          w_col_high;
   logic [1:0]    w_low_col;
   logic [3:0]    w_code;

   function automatic logic [3:0] key_map(input logic [1:0] row, input logic [1:0] col);
      logic [3:0] code;
      case ({row, col})
         4'h0:    code = 4'h1;
         4'h1:    code = 4'h2;
         4'h2:    code = 4'h3;
         4'h3:    code = 4'hA;
         4'h4:    code = 4'h4;
         4'h5:    code = 4'h5;
         4'h6:    code = 4'h6;
         4'h7:    code = 4'hB;
         4'h8:    code = 4'h7;
         4'h9:    code = 4'h8;
         4'hA:    code = 4'h9;
         4'hB:    code = 4'hC;
         4'hC:    code = 4'hE;
         4'hD:    code = 4'h0;
         4'hE:    code = 4'hF;
         default: code = 4'hD;
      endcase
      return code;
   endfunction

   assign w_any_low  = (r_cols_s != 4'hF);
   assign w_col_high = r_cols_s[r_col];
   assign w_code     = key_map(r_row, r_col);

   // Lowest-indexed active column wins when several are pressed on one row.
   always_comb begin
      w_low_col = 2'd3;
      if (!r_cols_s[0]) begin
         w_low_col = 2'd0;
      end else if (!r_cols_s[1]) begin
         w_low_col = 2'd1;
      end else if (!r_cols_s[2]) begin
         w_low_col = 2'd2;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_row_nxt   = r_row;
      w_col_nxt   = r_col;
      w_dwell_nxt = r_dwell;
      w_db_nxt    = r_db;
      w_fire      = 1'b0;
      case (r_state)
         StScan: begin
            if (r_dwell == DWELL_LAST) begin
               w_dwell_nxt = '0;
               if (w_any_low) begin
                  w_col_nxt   = w_low_col;
                  w_db_nxt    = '0;
                  w_state_nxt = StDebounce;
               end else begin
                  w_row_nxt = r_row + 2'd1;
               end
            end else begin
               w_dwell_nxt = r_dwell + DW'(1);
            end
         end
         StDebounce: begin
            if (w_col_high) begin
               w_row_nxt   = r_row + 2'd1;
               w_dwell_nxt = '0;
               w_db_nxt    = '0;
               w_state_nxt = StScan;
            end else if (r_db == DB_LAST) begin
               w_fire      = 1'b1;
               w_db_nxt    = '0;
               w_state_nxt = StHeld;
            end else begin
               w_db_nxt = r_db + BW'(1);
            end
         end
         StHeld: begin
            if (w_col_high) begin
               w_db_nxt    = '0;
               w_state_nxt = StRelease;
            end
         end
         StRelease: begin
            if (!w_col_high) begin
               w_db_nxt    = '0;
               w_state_nxt = StHeld;
            end else if (r_db == DB_LAST) begin
               w_row_nxt   = r_row + 2'd1;
               w_dwell_nxt = '0;
               w_db_nxt    = '0;
               w_state_nxt = StScan;
            end else begin
               w_db_nxt = r_db + BW'(1);
            end
         end
         default: begin
            w_state_nxt = StScan;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_cols_meta <= 4'hF;
         r_cols_s    <= 4'hF;
         r_state     <= StScan;
         r_row       <= 2'd0;
         r_col       <= 2'd0;
         r_dwell     <= '0;
         r_db        <= '0;
         r_key_valid <= 1'b0;
         r_key_code  <= 4'h0;
         r_digit_new <= 4'h0;
         r_digit_old <= 4'h0;
      end else begin
         r_cols_meta <= cols_n;
         r_cols_s    <= r_cols_meta;
         r_state     <= w_state_nxt;
         r_row       <= w_row_nxt;
         r_col       <= w_col_nxt;
         r_dwell     <= w_dwell_nxt;
         r_db        <= w_db_nxt;
         r_key_valid <= w_fire;
         if (w_fire) begin
            r_key_code  <= w_code;
            r_digit_new <= w_code;
            r_digit_old <= r_digit_new;
         end
      end
   end

   assign rows_n    = ~(4'b1000 >> r_row);
   assign key_valid = r_key_valid;
   assign key_code  = r_key_code;
   assign key_held  = (r_state == StHeld) || (r_state == StRelease);
   assign digit_new = r_digit_new;
   assign digit_old = r_digit_old;

endmodule
